// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared state type and arithmetic helpers for the FFT bin reader
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } fft_state_e;

  // Fixed carrier widths; callers narrow results with a size cast.
  localparam int BITREV_W  = 16;
  localparam int BITREV_IW = $clog2(BITREV_W);
  localparam int MAG_IN_W  = 32;

  // Reverse the low w bits of v; bits at and above w come back as zero.
  function automatic logic [BITREV_W-1:0] bitrev(input logic [BITREV_W-1:0] v, input int w);
    logic [BITREV_W-1:0] r;
    r = '0;
    for (int i = 0; i < BITREV_W; i++) begin
      if (i < w) r[BITREV_IW'(i)] = v[BITREV_IW'(w - 1 - i)];
    end
    return r;
  endfunction

  // |re|+|im| with one extra bit so the most negative component maps exactly.
  function automatic logic [MAG_IN_W:0] cplx_mag_l1(input logic signed [MAG_IN_W-1:0] re,
                                                    input logic signed [MAG_IN_W-1:0] im);
    logic [MAG_IN_W:0] a_re;
    logic [MAG_IN_W:0] a_im;
    a_re = re[MAG_IN_W-1] ? {1'b0, -re} : {1'b0, re};
    a_im = im[MAG_IN_W-1] ? {1'b0, -im} : {1'b0, im};
    return a_re + a_im;
  endfunction

endpackage

// File: rtl/fft_bin_ram.sv
// rtl/fft_bin_ram.sv - simple dual-port bin store, one write port, registered read port
module fft_bin_ram #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // No reset on the array or read register so the store maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fft_bin_reader.sv
// rtl/fft_bin_reader.sv - captures one FFT frame, replays it in natural order and reports the peak bin
module fft_bin_reader
  import fft_pkg::*;
#(
  parameter int N           = 128,
  parameter int DATA_WIDTH  = 8,
  parameter int BIT_REVERSE = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_fft_data_flag,
  input  logic [2*DATA_WIDTH-1:0] in_fft_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_re,
  output logic [DATA_WIDTH-1:0]   out_im,
  output logic [$clog2(N)-1:0]    out_index,
  output logic                    out_last,
  output logic                    peak_valid,
  output logic [$clog2(N)-1:0]    peak_index,
  output logic [DATA_WIDTH:0]     peak_mag,
  output logic                    frame_err,
  output logic                    overflow
);

  localparam int AW = $clog2(N);
  localparam int DW = DATA_WIDTH;
  localparam int SW = 2 * DATA_WIDTH;
  localparam int MW = DATA_WIDTH + 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  fft_state_e    state_q, state_d;
  logic          flag_prev_q, flag_prev_d;
  logic [AW-1:0] count_q, count_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          rd_all_q, rd_all_d;
  logic          rd_pend_q, rd_pend_d;
  logic [AW-1:0] rd_idx_q, rd_idx_d;
  logic          out_valid_q, out_valid_d;
  logic [SW-1:0] out_data_q, out_data_d;
  logic [AW-1:0] out_idx_q, out_idx_d;
  logic          skid_valid_q, skid_valid_d;
  logic [SW-1:0] skid_data_q, skid_data_d;
  logic [AW-1:0] skid_idx_q, skid_idx_d;
  logic [MW-1:0] run_mag_q, run_mag_d;
  logic [AW-1:0] run_idx_q, run_idx_d;
  logic          peak_valid_q, peak_valid_d;
  logic [AW-1:0] peak_idx_q, peak_idx_d;
  logic [MW-1:0] peak_mag_q, peak_mag_d;
  logic          frame_err_q, frame_err_d;
  logic          overflow_q, overflow_d;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          rd_en;
  logic [SW-1:0] rd_data;
  logic          frame_start;
  logic          pop;
  logic          head_free;
  logic [1:0]    occ;
  logic [1:0]    occ_after;
  logic [MW-1:0] head_mag;

  fft_bin_ram #(.DEPTH(N), .WIDTH(SW)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (in_fft_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr_q),
    .rd_data (rd_data)
  );

  // Only a rising flag edge opens a frame, so a run already in progress is never mistaken for one.
  assign frame_start = in_fft_data_flag & ~flag_prev_q;
  assign wr_addr     = (BIT_REVERSE != 0) ? AW'(bitrev(BITREV_W'(count_q), AW)) : count_q;
  assign pop         = out_valid_q & out_ready;
  assign head_free   = ~out_valid_q | pop;
  // Output register + skid + in-flight read together never exceed two bins.
  assign occ         = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(rd_pend_q);
  assign occ_after   = occ - 2'(pop);
  assign head_mag    = MW'(cplx_mag_l1(MAG_IN_W'(signed'(out_data_q[SW-1:DW])),
                                       MAG_IN_W'(signed'(out_data_q[DW-1:0]))));

  // Next-state logic: capture sequencing, read prefetch, skid stage and peak tracking.
  always_comb begin
    state_d      = state_q;
    flag_prev_d  = in_fft_data_flag;
    count_d      = count_q;
    rd_addr_d    = rd_addr_q;
    rd_all_d     = rd_all_q;
    rd_pend_d    = 1'b0;
    rd_idx_d     = rd_idx_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_idx_d    = out_idx_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_idx_d   = skid_idx_q;
    run_mag_d    = run_mag_q;
    run_idx_d    = run_idx_q;
    peak_valid_d = 1'b0;
    peak_idx_d   = peak_idx_q;
    peak_mag_d   = peak_mag_q;
    frame_err_d  = 1'b0;
    overflow_d   = 1'b0;
    wr_en        = 1'b0;
    rd_en        = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          wr_en   = 1'b1;
          count_d = AW'(1);
          state_d = CAPTURE;
        end
      end

      CAPTURE: begin
        if (in_fft_data_flag) begin
          wr_en = 1'b1;
          if (count_q == LAST_IDX) begin
            count_d   = '0;
            rd_addr_d = '0;
            rd_all_d  = 1'b0;
            run_mag_d = '0;
            run_idx_d = '0;
            state_d   = DRAIN;
          end else begin
            count_d = count_q + 1'b1;
          end
        end else begin
          frame_err_d = 1'b1;
          count_d     = '0;
          state_d     = IDLE;
        end
      end

      DRAIN: begin
        if (frame_start) overflow_d = 1'b1;

        rd_en     = ~rd_all_q & (occ_after < 2'd2);
        rd_pend_d = rd_en;
        rd_idx_d  = rd_addr_q;
        if (rd_en) begin
          if (rd_addr_q == LAST_IDX) rd_all_d = 1'b1;
          else                       rd_addr_d = rd_addr_q + 1'b1;
        end

        if (head_free) begin
          if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            out_idx_d    = skid_idx_q;
            skid_valid_d = rd_pend_q;
            skid_data_d  = rd_data;
            skid_idx_d   = rd_idx_q;
          end else begin
            out_valid_d = rd_pend_q;
            if (rd_pend_q) begin
              out_data_d = rd_data;
              out_idx_d  = rd_idx_q;
            end
          end
        end else if (rd_pend_q) begin
          skid_valid_d = 1'b1;
          skid_data_d  = rd_data;
          skid_idx_d   = rd_idx_q;
        end

        if (pop) begin
          if (head_mag > run_mag_q) begin
            run_mag_d = head_mag;
            run_idx_d = out_idx_q;
          end
          if (out_idx_q == LAST_IDX) begin
            peak_valid_d = 1'b1;
            peak_mag_d   = run_mag_d;
            peak_idx_d   = run_idx_d;
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            rd_pend_d    = 1'b0;
            state_d      = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State register; flag history resets high so a run straddling reset is ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      flag_prev_q  <= 1'b1;
      count_q      <= '0;
      rd_addr_q    <= '0;
      rd_all_q     <= 1'b0;
      rd_pend_q    <= 1'b0;
      rd_idx_q     <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_idx_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_idx_q   <= '0;
      run_mag_q    <= '0;
      run_idx_q    <= '0;
      peak_valid_q <= 1'b0;
      peak_idx_q   <= '0;
      peak_mag_q   <= '0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      flag_prev_q  <= flag_prev_d;
      count_q      <= count_d;
      rd_addr_q    <= rd_addr_d;
      rd_all_q     <= rd_all_d;
      rd_pend_q    <= rd_pend_d;
      rd_idx_q     <= rd_idx_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_idx_q    <= out_idx_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_idx_q   <= skid_idx_d;
      run_mag_q    <= run_mag_d;
      run_idx_q    <= run_idx_d;
      peak_valid_q <= peak_valid_d;
      peak_idx_q   <= peak_idx_d;
      peak_mag_q   <= peak_mag_d;
      frame_err_q  <= frame_err_d;
      overflow_q   <= overflow_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_re     = out_data_q[SW-1:DW];
  assign out_im     = out_data_q[DW-1:0];
  assign out_index  = out_idx_q;
  assign out_last   = out_valid_q & (out_idx_q == LAST_IDX);
  assign peak_valid = peak_valid_q;
  assign peak_index = peak_idx_q;
  assign peak_mag   = peak_mag_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_fft_bin_reader.sv
// tb/tb_fft_bin_reader.sv - directed self-checking bench for fft_bin_reader
module tb_fft_bin_reader;

  localparam int N  = 128;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_fft_data_flag;
  logic [15:0]   in_fft_data;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_re;
  logic [7:0]    out_im;
  logic [6:0]    out_index;
  logic          out_last;
  logic          peak_valid;
  logic [6:0]    peak_index;
  logic [8:0]    peak_mag;
  logic          frame_err;
  logic          overflow;

  always #5 clk = ~clk;

  fft_bin_reader #(.N(N), .DATA_WIDTH(DW), .BIT_REVERSE(1)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_fft_data_flag (in_fft_data_flag),
    .in_fft_data      (in_fft_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_re           (out_re),
    .out_im           (out_im),
    .out_index        (out_index),
    .out_last         (out_last),
    .peak_valid       (peak_valid),
    .peak_index       (peak_index),
    .peak_mag         (peak_mag),
    .frame_err        (frame_err),
    .overflow         (overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] frame_bins [N];

  typedef struct {
    int          a_idx;
    logic [15:0] a_val;
    int          b_idx;
    logic [15:0] b_val;
    bit          rnd;
    int          exp_idx;
    int          exp_mag;
  } vec_t;
  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int brev7(input int k);
    int r = 0;
    for (int i = 0; i < 7; i++) if (k[i]) r = r | (1 << (6 - i));
    return r;
  endfunction

  task automatic natural_frame();
    for (int j = 0; j < N; j++) frame_bins[j] = {8'(j), 8'(-j)};
  endtask

  task automatic two_bin_frame(input int a, input logic [15:0] av, input int b, input logic [15:0] bv);
    for (int j = 0; j < N; j++) frame_bins[j] = 16'h0000;
    frame_bins[a] = av;
    frame_bins[b] = bv;
  endtask

  // Called at a negedge; feeds bins in bit-reversed order and returns at the negedge after the last sample.
  task automatic send_frame();
    for (int k = 0; k < N; k++) begin
      in_fft_data_flag = 1'b1;
      in_fft_data      = frame_bins[brev7(k)];
      @(negedge clk);
    end
    in_fft_data_flag = 1'b0;
    in_fft_data      = 16'h0000;
  endtask

  // Collects N bins, checks order/payload/stall stability, then the peak report.
  task automatic drain(input bit rnd, input int exp_pidx, input int exp_pmag, output int cycles);
    int          j = 0;
    bit          stalled = 0;
    logic [23:0] held = '0;
    bit          rdy;
    cycles = 0;
    while (j < N && cycles < 5000) begin
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      if (stalled) chk("stall_hold", {out_valid, out_last, out_index, out_re, out_im}, {1'b1, held});
      if (out_valid) begin
        if (rdy) begin
          chk($sformatf("bin%0d", j), {out_last, out_index, out_re, out_im},
              {(j == N - 1), 7'(j), frame_bins[j]});
          j++;
          stalled = 0;
        end else begin
          stalled = 1;
          held    = {out_last, out_index, out_re, out_im};
        end
      end else begin
        stalled = 0;
      end
      @(negedge clk);
      cycles++;
    end
    out_ready = 1'b1;
    chk("drain_count", j, N);
    chk("peak_valid", peak_valid, 1);
    chk("peak_index", peak_index, exp_pidx);
    chk("peak_mag", peak_mag, exp_pmag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int cnt;
    int first;
    bit found;

    vecs[0] = '{37, {8'h80, 8'h05}, 90,  {8'h7f, 8'h06}, 1'b0, 37,  133};
    vecs[1] = '{10, {8'h32, 8'h32}, 20,  {8'h32, 8'h32}, 1'b1, 10,  100};
    vecs[2] = '{0,  16'h0000,       64,  16'h0000,       1'b0, 0,   0};
    vecs[3] = '{5,  {8'h7f, 8'h7f}, 127, {8'h80, 8'h80}, 1'b1, 127, 256};
    vecs[4] = '{4,  {8'hfe, 8'h00}, 3,   {8'h01, 8'hff}, 1'b0, 3,   2};

    rst_n = 1'b0;
    in_fft_data_flag = 1'b0;
    in_fft_data = 16'h0000;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {out_valid, out_last, out_index, out_re, out_im, peak_valid,
                          peak_index, peak_mag, frame_err, overflow}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Natural-order frame, first-valid latency and full-rate throughput.
    natural_frame();
    send_frame();
    chk("lat_edge1", out_valid, 0);
    @(negedge clk);
    chk("lat_edge2", out_valid, 0);
    @(negedge clk);
    chk("lat_edge3", {out_valid, out_index}, {1'b1, 7'd0});
    drain(1'b0, 127, 254, cyc);
    chk("throughput", cyc, N);

    // Peak vectors; each frame starts in the cycle right after the previous last handshake.
    for (int v = 0; v < 5; v++) begin
      two_bin_frame(vecs[v].a_idx, vecs[v].a_val, vecs[v].b_idx, vecs[v].b_val);
      send_frame();
      drain(vecs[v].rnd, vecs[v].exp_idx, vecs[v].exp_mag, cyc);
    end

    // Backpressure on the natural frame, then peak pulse width and hold.
    natural_frame();
    send_frame();
    drain(1'b1, 127, 254, cyc);
    @(negedge clk);
    chk("peak_pulse_end", {peak_valid, peak_index, peak_mag}, {1'b0, 7'd127, 9'd254});

    // Short frame aborts with frame_err and emits nothing.
    for (int k = 0; k < 60; k++) begin
      in_fft_data_flag = 1'b1;
      in_fft_data = 16'($urandom);
      @(negedge clk);
    end
    in_fft_data_flag = 1'b0;
    @(negedge clk);
    chk("frame_err_pulse", frame_err, 1);
    @(negedge clk);
    chk("frame_err_clear", frame_err, 0);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid) cnt++;
      @(negedge clk);
    end
    chk("short_no_output", cnt, 0);
    natural_frame();
    send_frame();
    drain(1'b0, 127, 254, cyc);

    // Overflow: second frame start during a stalled drain.
    repeat (2) @(negedge clk);
    send_frame();
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    cnt = 0;
    first = -1;
    for (int k = 0; k < 20; k++) begin
      in_fft_data_flag = 1'b1;
      in_fft_data = 16'ha5a5;
      @(negedge clk);
      if (overflow) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
    in_fft_data_flag = 1'b0;
    in_fft_data = 16'h0000;
    @(negedge clk);
    if (overflow) cnt++;
    chk("overflow_count", cnt, 1);
    chk("overflow_timing", first, 0);
    drain(1'b0, 127, 254, cyc);
    cnt = 0;
    for (int k = 0; k < 300; k++) begin
      if (out_valid || overflow) cnt++;
      @(negedge clk);
    end
    chk("dropped_frame_silent", cnt, 0);

    // Reset while bin 50 is presented.
    natural_frame();
    send_frame();
    out_ready = 1'b1;
    found = 0;
    for (int k = 0; k < 400 && !found; k++) begin
      if (out_valid && out_index == 7'd50) found = 1;
      else @(negedge clk);
    end
    chk("reach_bin50", found, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_mid_drain", {out_valid, out_last, out_index, out_re, out_im, peak_valid,
                            peak_index, peak_mag, frame_err, overflow}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    two_bin_frame(vecs[0].a_idx, vecs[0].a_val, vecs[0].b_idx, vecs[0].b_val);
    send_frame();
    drain(1'b0, 37, 133, cyc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_bin_reader.md
# fft_bin_reader

Receive-side consumer of the FFT_Base2 output stream. Captures one frame of N complex bins presented as a contiguous `out_fft_data_flag` run. Stores the bins, undoing bit-reversed ordering when configured, and replays them in natural bin order on a valid/ready stream. While replaying, it reports the peak-magnitude bin. It sits directly downstream of the FFT core, before any host or DMA interface.

## Interface

- `N`, 128: FFT length, power of two, 8..1024.
- `DATA_WIDTH`, 8: width of each signed re/im component.
- `BIT_REVERSE`, 1: 1 means input bins arrive in bit-reversed order; 0 means natural order.

Ports:

- `clk` in, 1: sole clock.
- `rst_n` in, 1: reset, synchronous, active-low.
- `in_fft_data_flag` in, 1: input bin valid; one frame is one contiguous high run.
- `in_fft_data` in, 2*DATA_WIDTH: {re, im}, re in the MSBs, two's complement.
- `out_valid` out, 1: output bin valid.
- `out_ready` in, 1: downstream accept.
- `out_re` out, DATA_WIDTH: bin real part.
- `out_im` out, DATA_WIDTH: bin imaginary part.
- `out_index` out, $clog2(N): natural bin index.
- `out_last` out, 1: high with bin N-1.
- `peak_valid` out, 1: one-cycle pulse once per drained frame.
- `peak_index` out, $clog2(N): index of the largest-magnitude bin.
- `peak_mag` out, DATA_WIDTH+1: |re|+|im| of that bin, unsigned.
- `frame_err` out, 1: one-cycle pulse when a frame is aborted (short run).
- `overflow` out, 1: one-cycle pulse when a frame start is dropped because the block is busy.

## Operation

- States are IDLE, CAPTURE, DRAIN. Reset enters IDLE.
- Frame start is a cycle with flag=1 where the previous cycle had flag=0. A run already high when the block enters IDLE is ignored until the flag falls.
- IDLE:
  - On a frame start, write the sample, set the write count to 1, and go to CAPTURE.
  - N=1 frames are not supported.
- CAPTURE:
  - Each flag=1 cycle writes the sample at address bitrev(count) when BIT_REVERSE=1, otherwise at address count. Then count increments.
  - When the N-th sample is written, go to DRAIN.
  - If flag=0 before N samples, pulse `frame_err`, discard the frame, and go to IDLE.
- DRAIN:
  - Read addresses 0..N-1 sequentially. Each presented bin carries `out_index` equal to the address.
  - The output is a 2-entry skid or prefetch stage, so a bin is presented every cycle while `out_ready`=1.
  - Once asserted, `out_valid` holds and the payload stays stable until the handshake (`out_valid`&`out_ready`).
  - On the handshake of bin N-1 (`out_last`=1), go to IDLE.
  - A frame start seen in DRAIN pulses `overflow`; that entire run is ignored.
  - Flag samples past N in a run are not a new frame and are ignored silently.
- Peak:
  - Magnitude is |re|+|im|, computed at DATA_WIDTH+1 bits, so |−2^(DW−1)| = 2^(DW−1) exactly.
  - It is evaluated on each output handshake in natural order.
  - The comparison is strictly greater, so on ties the lowest index wins.
  - The running peak is cleared on entry to DRAIN.
- Reset at any time:
  - All counters clear, state goes to IDLE, and buffered data is abandoned.
  - The memory contents need no reset.

## Timing

- Reset values: `out_valid`=0, `out_last`=0, `out_index`=0, `out_re`=`out_im`=0, `peak_valid`=0, `peak_index`=0, `peak_mag`=0, `frame_err`=0, `overflow`=0.
- The memory has a synchronous read port with 1-cycle read latency.
- The first `out_valid` rises 2 cycles after the clock edge that captured sample N-1, provided `out_ready` is held high.
- With `out_ready`=1 continuously, frame throughput is N capture cycles, plus 2 cycles of latency, plus N drain cycles.
- `peak_valid`, `peak_index` and `peak_mag`:
  - `peak_valid` pulses in the cycle after the bin N-1 handshake.
  - `peak_index` and `peak_mag` hold their value until the next `peak_valid`.
- `frame_err` pulses in the cycle after the first low flag sample of the short run.
- `overflow` pulses in the cycle after the frame-start sample.
- Minimum idle gap: a frame start may occur in the cycle right after the last drain handshake and is accepted.

## Structure

- Shared package `fft_pkg`:
  - state enum {IDLE, CAPTURE, DRAIN};
  - a `bitrev` function parameterised by width;
  - a `cplx_mag_l1` function (|re|+|im| at DATA_WIDTH+1 bits).
- Sub-module `fft_bin_ram`:
  - simple dual-port RAM, N×2*DATA_WIDTH;
  - one write port and one registered read port;
  - inferable as block RAM.
- The FSM, counters, skid stage and peak tracker live in the top.

## Test plan

- Natural-order frame:
  - Setup: N=128, BIT_REVERSE=1; input sample k = {re=bitrev(k), im=−bitrev(k)}.
  - Required: 128 bins with `out_index`=j, re=j, im=−j, and `out_last` only at j=127.
- Backpressure:
  - Stimulus: `out_ready` random at 50%.
  - Required: identical bin sequence, payload stable while stalled, no drops or duplicates.
- Peak:
  - Stimulus: bin 37 = {−128, 5} and bin 90 = {127, 6}; all others zero.
  - Required: `peak_index`=37 and `peak_mag`=133. Second case: with bins 10 and 20 both = {50, 50}, required `peak_index`=10.
- Short frame:
  - Stimulus: flag high for 60 cycles, then low.
  - Required: `frame_err` pulse, no `out_valid`. A following full frame drains correctly.
- Overflow:
  - Stimulus: second frame start during DRAIN with `out_ready`=0.
  - Required: `overflow` pulses once, the first frame drains intact, and the second frame is not emitted.
- Reset mid-drain:
  - Stimulus: `rst_n`=0 at bin 50.
  - Required: all outputs take their reset values the next cycle. A new frame after reset drains from index 0.
